// File: rtl/memory_access_pipe.sv
// Y86-64 memory stage: one req/ack data-memory transaction per instruction plus the M->W register.
// Optional MEM_TIMEOUT_EN abandons unacknowledged requests after TIMEOUT_CYCLES wait cycles.
module memory_access_pipe #(
    parameter int unsigned DMEM_BYTES     = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  M_stat_i,
    input  logic [63:0] M_pc_i,
    input  logic [3:0]  M_icode_i,
    input  logic [3:0]  M_ifunc_i,
    input  logic        M_Cnd_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic        W_stall_i,
    input  logic        W_bubble_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        m_busy_o,
    output logic [2:0]  m_stat_o,
    output logic [2:0]  W_stat_o,
    output logic [3:0]  W_icode_o,
    output logic [63:0] W_valE_o,
    output logic [63:0] W_valM_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o
);

    localparam logic [2:0] SAok    = 3'd1;
    localparam logic [2:0] SAdr    = 3'd3;
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [3:0] RNone   = 4'hF;

    typedef enum logic {StIdle, StWait} state_e;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } wreg_t;

    localparam wreg_t WBubble = '{stat: SAok, icode: INop, val_e: 64'd0, val_m: 64'd0,
                                  dst_e: RNone, dst_m: RNone};

    state_e      state_q, state_d;
    wreg_t       w_q, w_d;
    logic        is_read, is_write, mem_op, addr_err, legal;
    logic        expired, abandon;
    logic [63:0] addr;

    always_comb begin
        is_read  = (M_icode_i == IMrmovq) || (M_icode_i == IPopq) || (M_icode_i == IRet);
        is_write = (M_icode_i == IRmmovq) || (M_icode_i == IPushq) || (M_icode_i == ICall);
        mem_op   = is_read || is_write;
        addr     = ((M_icode_i == IPopq) || (M_icode_i == IRet)) ? M_valA_i : M_valE_i;
        // 65-bit sum so addresses near 2^64 cannot wrap into range
        addr_err = mem_op && (({1'b0, addr} + 65'd7) >= 65'(DMEM_BYTES));
        legal    = mem_op && (M_stat_i == SAok) && !addr_err;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == StWait && state_d == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        m_busy_o   = 1'b0;
        abandon    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (legal && !W_stall_i) begin
                    dmem_req_o = 1'b1;
                    if (!dmem_ack_i) begin
                        m_busy_o = 1'b1;
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                if (dmem_ack_i) begin
                    dmem_req_o = 1'b1;
                    state_d    = StIdle;
                end else if (expired) begin
                    abandon = 1'b1;
                    state_d = StIdle;
                end else begin
                    dmem_req_o = 1'b1;
                    m_busy_o   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dmem_we_o    = is_write;
    assign dmem_addr_o  = addr;
    assign dmem_wdata_o = M_valA_i;
    assign m_stat_o     = (addr_err || abandon) ? SAdr : M_stat_i;

    always_comb begin
        w_d = w_q;
        if (W_bubble_i || m_busy_o) begin
            w_d = WBubble;
        end else if (!W_stall_i) begin
            w_d.stat  = m_stat_o;
            w_d.icode = M_icode_i;
            w_d.val_e = M_valE_i;
            // only data actually acknowledged for a live request reaches W
            w_d.val_m = (is_read && dmem_req_o && dmem_ack_i) ? dmem_rdata_i : 64'd0;
            w_d.dst_e = M_dstE_i;
            w_d.dst_m = M_dstM_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            w_q     <= WBubble;
        end else begin
            state_q <= state_d;
            if (!W_stall_i) begin
                w_q <= w_d;
            end
        end
    end

    assign W_stat_o  = w_q.stat;
    assign W_icode_o = w_q.icode;
    assign W_valE_o  = w_q.val_e;
    assign W_valM_o  = w_q.val_m;
    assign W_dstE_o  = w_q.dst_e;
    assign W_dstM_o  = w_q.dst_m;

    logic unused_m;
    assign unused_m = ^{M_pc_i, M_ifunc_i, M_Cnd_i};

endmodule

// File: tb/tb_memory_access_pipe.sv
// Scoreboard bench for memory_access_pipe; expected W contents are queued when an
// instruction is driven and popped when W should capture it.
module tb_memory_access_pipe;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_t;

    localparam w_t Bubble = '{stat: 3'd1, icode: 4'h1, val_e: 64'd0, val_m: 64'd0,
                              dst_e: 4'hF, dst_m: 4'hF};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_stat;
    logic [63:0] m_pc;
    logic [3:0]  m_icode, m_ifunc;
    logic        m_cnd;
    logic [63:0] m_vale, m_vala;
    logic [3:0]  m_dste, m_dstm;
    logic        w_stall, w_bubble;
    logic        req, we, ack, busy;
    logic [63:0] addr, wdata, rdata;
    logic [2:0]  stat_o;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode, w_dste, w_dstm;
    logic [63:0] w_vale, w_valm;
    w_t          w_obs, e;

    int vectors = 0;
    int miscompares = 0;
    w_t exp_q[$];

    assign w_obs = {w_stat, w_icode, w_vale, w_valm, w_dste, w_dstm};

    always #5 clk = ~clk;

    memory_access_pipe dut (
        .clk_i(clk), .rst_i(rst),
        .M_stat_i(m_stat), .M_pc_i(m_pc), .M_icode_i(m_icode), .M_ifunc_i(m_ifunc),
        .M_Cnd_i(m_cnd), .M_valE_i(m_vale), .M_valA_i(m_vala), .M_dstE_i(m_dste),
        .M_dstM_i(m_dstm), .W_stall_i(w_stall), .W_bubble_i(w_bubble),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_ack_i(ack), .dmem_rdata_i(rdata), .m_busy_o(busy), .m_stat_o(stat_o),
        .W_stat_o(w_stat), .W_icode_o(w_icode), .W_valE_o(w_vale), .W_valM_o(w_valm),
        .W_dstE_o(w_dste), .W_dstM_o(w_dstm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        m_stat = s; m_icode = ic; m_vale = ve; m_vala = va; m_dste = de; m_dstm = dm;
        m_pc = 64'h100; m_ifunc = 4'h0; m_cnd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_stall = 1'b0; w_bubble = 1'b0; ack = 1'b0; rdata = '0;
        set_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        step(); step();
        vectors++;
        if (w_obs !== Bubble) begin
            miscompares++; $display("FAIL reset_w: got %h expected %h", w_obs, Bubble);
        end
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_req_busy: got %b%b expected 00", req, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_irmovq();
        set_m(3'd1, 4'h3, 64'd100, 64'd0, 4'h1, 4'hF);
        ack = 1'b1;  // stray ack with no request must be ignored
        exp_q.push_back('{stat: 3'd1, icode: 4'h3, val_e: 64'd100, val_m: 64'd0,
                          dst_e: 4'h1, dst_m: 4'hF});
        #1;
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL irmovq_noreq: got %b%b expected 00", req, busy);
        end
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL irmovq_w: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_mrmovq();
        set_m(3'd1, 4'h5, 64'h40, 64'd0, 4'hF, 4'h2);
        ack = 1'b0;
        exp_q.push_back('{stat: 3'd1, icode: 4'h5, val_e: 64'h40, val_m: 64'hDEADBEEF,
                          dst_e: 4'hF, dst_m: 4'h2});
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (req !== 1'b1 || busy !== 1'b1 || we !== 1'b0 || addr !== 64'h40) begin
                miscompares++;
                $display("FAIL mrmovq_wait%0d: got req=%b busy=%b we=%b addr=%h expected 1 1 0 40",
                         i, req, busy, we, addr);
            end
            step();
            vectors++;
            if (w_obs !== Bubble) begin
                miscompares++; $display("FAIL mrmovq_bubble%0d: got %h expected %h", i, w_obs, Bubble);
            end
        end
        ack = 1'b1; rdata = 64'hDEADBEEF;
        #1;
        vectors++;
        if (req !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mrmovq_ack: got req=%b busy=%b expected 1 0", req, busy);
        end
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL mrmovq_w: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_pushq();
        set_m(3'd1, 4'hA, 64'h1F8, 64'h55, 4'h4, 4'hF);
        ack = 1'b1;
        exp_q.push_back('{stat: 3'd1, icode: 4'hA, val_e: 64'h1F8, val_m: 64'd0,
                          dst_e: 4'h4, dst_m: 4'hF});
        #1;
        vectors++;
        if (req !== 1'b1 || we !== 1'b1 || addr !== 64'h1F8 || wdata !== 64'h55 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pushq_bus: got req=%b we=%b addr=%h wdata=%h busy=%b expected 1 1 1f8 55 0",
                     req, we, addr, wdata, busy);
        end
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL pushq_w: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_adr();
        // highest legal doubleword: 8184 + 7 = 8191
        set_m(3'd1, 4'h4, 64'd8184, 64'h9, 4'hF, 4'hF);
        ack = 1'b1;
        exp_q.push_back('{stat: 3'd1, icode: 4'h4, val_e: 64'd8184, val_m: 64'd0,
                          dst_e: 4'hF, dst_m: 4'hF});
        #1;
        vectors++;
        if (req !== 1'b1 || stat_o !== 3'd1) begin
            miscompares++; $display("FAIL adr_edge_ok: got req=%b stat=%0d expected 1 1", req, stat_o);
        end
        step();
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL adr_edge_w: got %h expected %h", w_obs, e);
        end
        set_m(3'd1, 4'h4, 64'd8190, 64'h9, 4'hF, 4'hF);
        exp_q.push_back('{stat: 3'd3, icode: 4'h4, val_e: 64'd8190, val_m: 64'd0,
                          dst_e: 4'hF, dst_m: 4'hF});
        #1;
        vectors++;
        if (req !== 1'b0 || stat_o !== 3'd3) begin
            miscompares++; $display("FAIL adr_req: got req=%b stat=%0d expected 0 3", req, stat_o);
        end
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL adr_w: got %h expected %h", w_obs, e);
        end
    endtask

    task automatic test_timeout();
        set_m(3'd1, 4'h5, 64'h80, 64'd0, 4'hF, 4'h3);
        ack = 1'b0;
`ifdef MEM_TIMEOUT_EN
        exp_q.push_back('{stat: 3'd3, icode: 4'h5, val_e: 64'h80, val_m: 64'd0,
                          dst_e: 4'hF, dst_m: 4'h3});
        for (int i = 0; i < 16; i++) begin
            #1;
            vectors++;
            if (busy !== 1'b1 || req !== 1'b1) begin
                miscompares++; $display("FAIL timeout_busy%0d: got %b%b expected 11", i, req, busy);
            end
            step();
        end
        #1;
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0 || stat_o !== 3'd3) begin
            miscompares++;
            $display("FAIL timeout_drop: got req=%b busy=%b stat=%0d expected 0 0 3", req, busy, stat_o);
        end
        step();
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL timeout_w: got %h expected %h", w_obs, e);
        end
`else
        exp_q.push_back('{stat: 3'd1, icode: 4'h5, val_e: 64'h80, val_m: 64'd7,
                          dst_e: 4'hF, dst_m: 4'h3});
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (busy !== 1'b1 || req !== 1'b1) begin
            miscompares++; $display("FAIL hold_busy: got %b%b expected 11", req, busy);
        end
        ack = 1'b1; rdata = 64'd7;
        step();
        ack = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (w_obs !== e) begin
            miscompares++; $display("FAIL hold_w: got %h expected %h", w_obs, e);
        end
`endif
    endtask

    task automatic test_reset_wait();
        set_m(3'd1, 4'h5, 64'h10, 64'd0, 4'hF, 4'h5);
        ack = 1'b0;
        step(); step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL rstwait_pre: got busy=%b expected 1", busy);
        end
        rst = 1'b1;
        set_m(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        step();
        rst = 1'b0;
        vectors++;
        if (req !== 1'b0 || busy !== 1'b0 || w_obs !== Bubble) begin
            miscompares++;
            $display("FAIL rstwait_drop: got req=%b busy=%b w=%h expected 0 0 %h", req, busy, w_obs, Bubble);
        end
        ack = 1'b1; rdata = 64'h1234;
        step();
        ack = 1'b0;
        vectors++;
        if (req !== 1'b0 || w_obs !== Bubble) begin
            miscompares++; $display("FAIL rstwait_lateack: got req=%b w=%h expected 0 %h", req, w_obs, Bubble);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_mrmovq();
        test_pushq();
        test_adr();
        test_timeout();
        test_reset_wait();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

endmodule

// File: doc/memory_access_pipe.md
# memory_access_pipe

Memory stage of the Y86-64 pipeline: consumes the M-register outputs of the execute stage (`M_stat/M_pc/M_icode/M_ifunc/M_Cnd/M_valE/M_valA/M_dstE/M_dstM`), runs at most one data-memory transaction per instruction over a req/ack handshake, and owns the M→W pipeline register. While a transaction is outstanding it asserts `m_busy_o` so the hazard unit stalls F/D/E/M, and it bubbles W.

## Interface
- `DMEM_BYTES`, 8192: size of the legal data address space; any access with `addr + 7 >= DMEM_BYTES` is an address error.
- `TIMEOUT_CYCLES`, 16: wait cycles before an unacknowledged request is abandoned (only with `MEM_TIMEOUT_EN`).
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `M_stat_i`/`M_pc_i`/`M_icode_i`/`M_ifunc_i`/`M_Cnd_i`/`M_valE_i`/`M_valA_i`/`M_dstE_i`/`M_dstM_i` in 3/64/4/4/1/64/64/4/4: current M-register contents.
- `W_stall_i` in 1: hold W register; no new memory request may start.
- `W_bubble_i` in 1: load W with a bubble.
- `dmem_req_o` out 1: request valid; held until ack or abandon.
- `dmem_we_o` out 1: 1 = write, 0 = read.
- `dmem_addr_o` out 64: byte address.
- `dmem_wdata_o` out 64: write data (`M_valA_i`).
- `dmem_ack_i` in 1: transaction complete this cycle.
- `dmem_rdata_i` in 64: read data, valid with ack.
- `m_busy_o` out 1: stall request to hazard unit.
- `m_stat_o` out 3: combinational stage status (to hazard unit).
- `W_stat_o`/`W_icode_o`/`W_valE_o`/`W_valM_o`/`W_dstE_o`/`W_dstM_o` out 3/4/64/64/4/4: W register.

## Operation
- Status codes: AOK=1, HLT=2, ADR=3, INS=4. Bubble = icode NOP(1), stat AOK, dstE=dstM=RNONE(0xF), valE=valM=0.
- Reads: MRMOVQ(5), POPQ(B), RET(9). Writes: RMMOVQ(4), PUSHQ(A), CALL(8). All other icodes: no access.
- Address: `M_valA_i` for POPQ/RET, else `M_valE_i`.
- Access suppressed (no request) when `M_stat_i != AOK`, address out of range, or `W_stall_i`=1.
- `m_stat_o`: ADR if access out of range or abandoned by timeout, else `M_stat_i`.
- FSM, two states:
  - IDLE: memory op legal and `W_stall_i`=0 → `dmem_req_o`=1 combinationally. Ack same cycle → stay IDLE, `m_busy_o`=0. No ack → WAIT, `m_busy_o`=1.
  - WAIT: `dmem_req_o`=1 and `m_busy_o`=1, address/we/wdata stable (taken from the stalled M inputs). Ack → IDLE, `m_busy_o`=0 that cycle. Timeout → IDLE, request dropped, `m_busy_o`=0, `m_stat_o`=ADR.
- W register update priority: `rst_i` → bubble; `W_stall_i` → hold; `W_bubble_i` or `m_busy_o` → bubble; else load M fields, `W_valM_o` = `dmem_rdata_i` for reads, 0 otherwise.
- Write data is never altered; `dmem_wdata_o` = `M_valA_i`.

## Timing
- Reset: FSM IDLE, timeout counter 0, W = bubble; `dmem_req_o`/`m_busy_o` low as soon as reset holds (outputs depend on M inputs, which reset to bubble).
- Zero-wait memory (ack in request cycle): no stall; W loads on next edge — 1-cycle M→W latency.
- N wait cycles: `m_busy_o` high N cycles; W receives N bubbles, then the instruction.
- Reset asserted in WAIT: request dropped next edge, FSM IDLE, W bubble; no ack is honoured after reset.
- Ack arriving in IDLE with no request: ignored.
- Timeout counter counts WAIT cycles; abandon occurs in the cycle the count equals `TIMEOUT_CYCLES`-1.

## Configuration
- `MEM_TIMEOUT_EN` defined: timeout counter present; abandoned access produces ADR in W.
- Not defined: no counter; WAIT holds indefinitely until ack.

## Test plan
- IRMOVQ icode 3, valE=100, dstE=1, ack unused → W_icode=3, W_valE=100, W_dstE=1, no request, 1-cycle latency.
- MRMOVQ addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF → `m_busy_o` high 3 cycles, 3 W bubbles, then W_valM=0xDEADBEEF, W_dstM=M_dstM.
- PUSHQ valE=0x1F8, valA=0x55, zero-wait ack → `dmem_we_o`=1, addr 0x1F8, wdata 0x55, no stall.
- RMMOVQ valE=8190 (DMEM_BYTES 8192) → no request, W_stat=ADR(3).
- With `MEM_TIMEOUT_EN`, MRMOVQ never acked → request dropped after 16 cycles, W_stat=ADR; without macro, `m_busy_o` still high after 100 cycles.
- Reset asserted during WAIT, then late ack → `dmem_req_o` low, W bubble, ack ignored.
